alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Sequences one ARM data-processing instruction through an external combinational ALU:
// accept, execute with condition check, then a one-cycle response with optional flag update.
module alu_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  dp_opcode,
   input  logic [3:0]  cond,
   input  logic        s_bit,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_op,
   output logic        alu_cin,
   input  logic [31:0] alu_out,
   input  logic        alu_c,
   input  logic        alu_z,
   input  logic        alu_n,
   input  logic        alu_v,
   output logic        rsp_valid,
   output logic [31:0] rsp_result,
   output logic        rsp_wr_en,
   output logic [3:0]  flags_nzcv,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [3:0]  opc_q, cond_q;
   logic        s_q, wr_en_q;
   logic [31:0] a_q, b_q;
   logic        pass, cmp_only, arith, accept;
   logic        n_f, z_f, c_f, v_f;

   assign {n_f, z_f, c_f, v_f} = flags_nzcv;
   assign state_dbg = state;

   // Handshake: a request transfers on a rising edge where req_valid and req_ready
   // are both high; req_ready is high only in IDLE and nothing is queued otherwise.
   assign accept = req_valid && req_ready;

   function automatic logic [4:0] map_op(input logic [3:0] opc);
      case (opc)
         4'h0, 4'h8: map_op = 5'b00000;
         4'h1, 4'h9: map_op = 5'b00011;
         4'h2, 4'hA: map_op = 5'b00110;
         4'h3:       map_op = 5'b01000;
         4'h4, 4'hB: map_op = 5'b00100;
         4'h5:       map_op = 5'b00101;
         4'h6:       map_op = 5'b00111;
         4'h7:       map_op = 5'b01001;
         4'hC:       map_op = 5'b00010;
         4'hD:       map_op = 5'b01010;
         4'hE:       map_op = 5'b00001;
         default:    map_op = 5'b01011;
      endcase
   endfunction

   always_comb begin
      case (cond_q)
         4'h0:    pass = z_f;
         4'h1:    pass = !z_f;
         4'h2:    pass = c_f;
         4'h3:    pass = !c_f;
         4'h4:    pass = n_f;
         4'h5:    pass = !n_f;
         4'h6:    pass = v_f;
         4'h7:    pass = !v_f;
         4'h8:    pass = c_f && !z_f;
         4'h9:    pass = !c_f || z_f;
         4'hA:    pass = (n_f == v_f);
         4'hB:    pass = (n_f != v_f);
         4'hC:    pass = !z_f && (n_f == v_f);
         4'hD:    pass = z_f || (n_f != v_f);
         4'hE:    pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

   // TST/TEQ/CMP/CMN only set flags; arithmetic ops also own C and V.
   assign cmp_only = (opc_q[3:2] == 2'b10);
   assign arith    = (opc_q inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB});

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      alu_a      = '0;
      alu_b      = '0;
      alu_op     = '0;
      alu_cin    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = EXEC;
         end
         EXEC: begin
            alu_a      = a_q;
            alu_b      = b_q;
            alu_op     = map_op(opc_q);
            alu_cin    = c_f;
            state_next = RESP;
         end
         RESP: begin
            rsp_valid  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign rsp_wr_en = wr_en_q && (state == RESP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         opc_q      <= '0;
         cond_q     <= '0;
         s_q        <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         rsp_result <= '0;
         wr_en_q    <= 1'b0;
         flags_nzcv <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            opc_q  <= dp_opcode;
            cond_q <= cond;
            s_q    <= s_bit;
            a_q    <= op_a;
            b_q    <= op_b;
         end
         if (state == EXEC) begin
            rsp_result <= pass ? alu_out : 32'd0;
            wr_en_q    <= pass && !cmp_only;
            if (pass && (s_q || cmp_only))
               flags_nzcv <= {alu_n, alu_z, arith ? alu_c : c_f, arith ? alu_v : v_f};
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: stand-in ALU, directed vector table, throughput and reset
// sequences, and randomized requests checked against an arithmetic reference model.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [3:0]  dp_opcode, cond;
   logic        s_bit;
   logic [31:0] op_a, op_b;
   logic [31:0] alu_a, alu_b, alu_out;
   logic [4:0]  alu_op;
   logic        alu_cin, alu_c, alu_z, alu_n, alu_v;
   logic        rsp_valid, rsp_wr_en;
   logic [31:0] rsp_result;
   logic [3:0]  flags_nzcv;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic junk_c = 1'b0, junk_v = 1'b0;
   logic [3:0] mflags;

   typedef struct {
      logic [3:0]  opc;
      logic [3:0]  cnd;
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        wr;
      logic [3:0]  fl;
   } vec_t;
   vec_t vt[12];
   logic [4:0] op_map[16];

   alu_sequencer dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .dp_opcode(dp_opcode), .cond(cond), .s_bit(s_bit), .op_a(op_a), .op_b(op_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
      .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_wr_en(rsp_wr_en),
      .flags_nzcv(flags_nzcv), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   // Logical ops present random C/V so a sequencer that wrongly takes them is exposed.
   always @(negedge clk) begin
      junk_c <= 1'($urandom);
      junk_v <= 1'($urandom);
   end

   // Stand-in ALU: x + y + ci forms, result flags from the sum.
   logic [31:0] ax, ay;
   logic        aci, is_ar;
   logic [32:0] asum;
   always_comb begin
      ax = '0; ay = '0; aci = 1'b0; is_ar = 1'b1; asum = '0;
      alu_out = '0;
      case (alu_op)
         5'b00100: begin ax = alu_a; ay = alu_b;  aci = 1'b0;    end
         5'b00101: begin ax = alu_a; ay = alu_b;  aci = alu_cin; end
         5'b00110: begin ax = alu_a; ay = ~alu_b; aci = 1'b1;    end
         5'b00111: begin ax = alu_a; ay = ~alu_b; aci = alu_cin; end
         5'b01000: begin ax = alu_b; ay = ~alu_a; aci = 1'b1;    end
         5'b01001: begin ax = alu_b; ay = ~alu_a; aci = alu_cin; end
         default:  is_ar = 1'b0;
      endcase
      asum = {1'b0, ax} + {1'b0, ay} + {32'd0, aci};
      if (is_ar) alu_out = asum[31:0];
      else begin
         case (alu_op)
            5'b00000: alu_out = alu_a & alu_b;
            5'b00001: alu_out = alu_a & ~alu_b;
            5'b00010: alu_out = alu_a | alu_b;
            5'b00011: alu_out = alu_a ^ alu_b;
            5'b01010: alu_out = alu_b;
            5'b01011: alu_out = ~alu_b;
            default:  alu_out = '0;
         endcase
      end
      alu_c = is_ar ? asum[32] : junk_c;
      alu_v = is_ar ? ((ax[31] == ay[31]) && (asum[31] != ax[31])) : junk_v;
      alu_z = (alu_out == 32'd0);
      alu_n = alu_out[31];
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: ARM rules with plain wide integer arithmetic.
   function automatic void model(input logic [3:0] opc, input logic [3:0] cnd, input logic s,
                                 input logic [31:0] a, input logic [31:0] b, input logic [3:0] fl,
                                 output logic [31:0] res, output logic wr, output logic [3:0] fl_o);
      logic n, z, c, v, pass, cmp_only, arith, nc, nv;
      longint ua, ub, sa, sb, ur, sr, ci, bor;
      logic [31:0] r;
      {n, z, c, v} = fl;
      case (cnd)
         4'h0: pass = z;          4'h1: pass = !z;
         4'h2: pass = c;          4'h3: pass = !c;
         4'h4: pass = n;          4'h5: pass = !n;
         4'h6: pass = v;          4'h7: pass = !v;
         4'h8: pass = c && !z;    4'h9: pass = !c || z;
         4'hA: pass = (n == v);   4'hB: pass = (n != v);
         4'hC: pass = !z && (n == v);
         4'hD: pass = z || (n != v);
         4'hE: pass = 1'b1;
         default: pass = 1'b0;
      endcase
      ua = {32'd0, a}; ub = {32'd0, b};
      sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
      ci = c ? 1 : 0; bor = c ? 0 : 1;
      arith = 1'b1; ur = 0; sr = 0; r = '0;
      case (opc)
         4'h2, 4'hA: begin ur = ua - ub;       sr = sa - sb;       end
         4'h3:       begin ur = ub - ua;       sr = sb - sa;       end
         4'h4, 4'hB: begin ur = ua + ub;       sr = sa + sb;       end
         4'h5:       begin ur = ua + ub + ci;  sr = sa + sb + ci;  end
         4'h6:       begin ur = ua - ub - bor; sr = sa - sb - bor; end
         4'h7:       begin ur = ub - ua - bor; sr = sb - sa - bor; end
         default:    arith = 1'b0;
      endcase
      if (arith) r = ur[31:0];
      else begin
         case (opc)
            4'h0, 4'h8: r = a & b;
            4'h1, 4'h9: r = a ^ b;
            4'hC:       r = a | b;
            4'hD:       r = b;
            4'hE:       r = a & ~b;
            default:    r = ~b;
         endcase
      end
      nc = (opc inside {4'h4, 4'h5, 4'hB}) ? (ur > 64'sd4294967295) : (ur >= 0);
      nv = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      cmp_only = (opc inside {4'h8, 4'h9, 4'hA, 4'hB});
      res  = pass ? r : 32'd0;
      wr   = pass && !cmp_only;
      fl_o = fl;
      if (pass && (s || cmp_only))
         fl_o = {r[31], (r == 32'd0), arith ? nc : c, arith ? nv : v};
   endfunction

   // Driver: one full request from accept through the response cycle.
   task automatic run_req(input logic [3:0] opc, input logic [3:0] cnd, input logic s,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                          output logic [31:0] got_res, output logic got_wr,
                          output logic [3:0] got_fl, output logic [4:0] got_op,
                          output logic got_cin);
      int n;
      got_res = '0; got_wr = 1'b0; got_fl = '0; got_op = '0; got_cin = 1'b0;
      dp_opcode = opc; cond = cnd; s_bit = s; op_a = a; op_b = b; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 8) begin
         tick();
         n++;
      end
      checks++;
      if (!req_ready) begin
         errors++;
         $display("FAIL accept_timeout: req_ready stayed %b after %0d cycles, required 1", req_ready, n);
         req_valid = 1'b0;
         return;
      end
      exp_q.push_back(exp_res);
      tick();
      req_valid = 1'b0;
      dp_opcode = 4'($urandom); cond = 4'($urandom); s_bit = 1'($urandom);
      op_a = $urandom; op_b = $urandom;
      check("exec_ready", 32'(req_ready), 32'd0);
      check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      check("exec_alu_a", alu_a, a);
      check("exec_alu_b", alu_b, b);
      got_op = alu_op; got_cin = alu_cin;
      tick();
      check("resp_rsp_valid", 32'(rsp_valid), 32'd1);
      got_res = rsp_result; got_wr = rsp_wr_en; got_fl = flags_nzcv;
      tick();
      check("after_rsp_valid", 32'(rsp_valid), 32'd0);
      check("after_wr_en", 32'(rsp_wr_en), 32'd0);
      check("after_result_hold", rsp_result, exp_res);
      check("after_ready", 32'(req_ready), 32'd1);
   endtask

   // Scoreboard: every response must match the oldest outstanding expectation.
   always @(negedge clk) begin : scoreboard
      logic [31:0] e;
      if (!reset && rsp_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: rsp_valid=1 result %h, required no response", rsp_result);
         end else begin
            e = exp_q.pop_front();
            check("sb_rsp_result", rsp_result, e);
         end
      end
   end

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       pick = 32'h0000_0000;
         1:       pick = 32'hFFFF_FFFF;
         2:       pick = 32'h7FFF_FFFF;
         3:       pick = 32'h8000_0000;
         4:       pick = 32'h0000_0001;
         default: pick = $urandom;
      endcase
   endfunction

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [31:0] r, er;
      logic        w, ew;
      logic [3:0]  f, ef, prev_fl;
      logic [4:0]  o;
      logic        ci;
      logic [3:0]  ropc, rcnd;
      logic        rs;
      logic [31:0] ra, rb;
      int          acc;

      op_map = '{5'b00000, 5'b00011, 5'b00110, 5'b01000, 5'b00100, 5'b00101, 5'b00111, 5'b01001,
                 5'b00000, 5'b00011, 5'b00110, 5'b00100, 5'b00010, 5'b01010, 5'b00001, 5'b01011};
      //         opc   cnd   s     a             b             res           wr    flags
      vt[0]  = '{4'h4, 4'hE, 1'b1, 32'h40000000, 32'h40000000, 32'h80000000, 1'b1, 4'b1001};
      vt[1]  = '{4'hA, 4'hE, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 1'b0, 4'b0110};
      vt[2]  = '{4'hD, 4'h0, 1'b0, 32'h00000000, 32'h00000005, 32'h00000005, 1'b1, 4'b0110};
      vt[3]  = '{4'hD, 4'h1, 1'b0, 32'h00000000, 32'h00000005, 32'h00000000, 1'b0, 4'b0110};
      vt[4]  = '{4'h5, 4'hE, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 4'b0110};
      vt[5]  = '{4'h5, 4'hE, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 4'b0110};
      vt[6]  = '{4'hD, 4'hE, 1'b1, 32'h00000000, 32'h80000000, 32'h80000000, 1'b1, 4'b1010};
      vt[7]  = '{4'h2, 4'hE, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 4'b1000};
      vt[8]  = '{4'hC, 4'hA, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 4'b1000};
      vt[9]  = '{4'hC, 4'hB, 1'b0, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b1, 4'b1000};
      vt[10] = '{4'h8, 4'hF, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 4'b1000};
      vt[11] = '{4'h9, 4'hE, 1'b0, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 4'b0100};

      reset = 1'b1; req_valid = 1'b0; dp_opcode = '0; cond = '0; s_bit = 1'b0;
      op_a = '0; op_b = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_result", rsp_result, 32'd0);
      check("rst_wr_en", 32'(rsp_wr_en), 32'd0);
      check("rst_flags", 32'(flags_nzcv), 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      check("rst_alu_cin", 32'(alu_cin), 32'd0);
      check("rst_state_idle", 32'(state_dbg), 32'd0);
      tick();

      // directed vector table, flags carry from row to row
      prev_fl = 4'b0000;
      for (int i = 0; i < 12; i++) begin
         run_req(vt[i].opc, vt[i].cnd, vt[i].s, vt[i].a, vt[i].b, vt[i].res, r, w, f, o, ci);
         check($sformatf("vec%0d_result", i), r, vt[i].res);
         check($sformatf("vec%0d_wr_en", i), 32'(w), 32'(vt[i].wr));
         check($sformatf("vec%0d_flags", i), 32'(f), 32'(vt[i].fl));
         check($sformatf("vec%0d_alu_op", i), 32'(o), 32'(op_map[vt[i].opc]));
         check($sformatf("vec%0d_alu_cin", i), 32'(ci), 32'(prev_fl[1]));
         prev_fl = vt[i].fl;
      end

      // req_valid held high: accepts on every third edge only
      req_valid = 1'b1; dp_opcode = 4'hD; cond = 4'hE; s_bit = 1'b0; op_a = '0;
      acc = 0;
      for (int c = 0; c < 12; c++) begin
         op_b = 32'h100 + 32'(c);
         check($sformatf("thru_ready_c%0d", c), 32'(req_ready), 32'((c % 3) == 0));
         if (req_ready) begin
            exp_q.push_back(op_b);
            acc++;
         end
         tick();
      end
      req_valid = 1'b0;
      check("thru_accepts", 32'(acc), 32'd4);
      check("thru_flags", 32'(flags_nzcv), 32'b0100);
      tick();

      // reset pulse while an ADDS is executing
      dp_opcode = 4'h4; cond = 4'hE; s_bit = 1'b1; op_a = 32'h40000000; op_b = 32'h40000000;
      req_valid = 1'b1;
      check("rstx_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      #1 reset = 1'b1;
      #1 reset = 1'b0;
      check("rstx_flags", 32'(flags_nzcv), 32'd0);
      check("rstx_ready_after", 32'(req_ready), 32'd1);
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("rstx_no_rsp_c%0d", c), 32'(rsp_valid), 32'd0);
         check($sformatf("rstx_flags_c%0d", c), 32'(flags_nzcv), 32'd0);
      end
      mflags = 4'b0000;
      model(4'h4, 4'hE, 1'b1, 32'h40000000, 32'h40000000, mflags, er, ew, ef);
      run_req(4'h4, 4'hE, 1'b1, 32'h40000000, 32'h40000000, er, r, w, f, o, ci);
      check("rstx_next_result", r, er);
      check("rstx_next_flags", 32'(f), 32'(ef));
      mflags = ef;

      // randomized requests against the reference model
      for (int i = 0; i < 60; i++) begin
         ropc = 4'($urandom_range(0, 15));
         rcnd = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
         rs   = 1'($urandom);
         ra   = pick();
         rb   = pick();
         model(ropc, rcnd, rs, ra, rb, mflags, er, ew, ef);
         run_req(ropc, rcnd, rs, ra, rb, er, r, w, f, o, ci);
         check($sformatf("rnd%0d_result op=%h c=%h", i, ropc, rcnd), r, er);
         check($sformatf("rnd%0d_wr_en", i), 32'(w), 32'(ew));
         check($sformatf("rnd%0d_flags", i), 32'(f), 32'(ef));
         check($sformatf("rnd%0d_alu_op", i), 32'(o), 32'(op_map[ropc]));
         check($sformatf("rnd%0d_alu_cin", i), 32'(ci), 32'(mflags[1]));
         mflags = ef;
      end

      repeat (3) tick();
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
